accelerator_core: RTL and testbench

Self-contained accelerator top with ping-pong global buffers (GBFs) and an internal deterministic GBF loader; it needs no data inputs.
- Loader fills paired activation/weight GBF banks.
- Compute engine runs a COL-lane multiply-accumulate over one bank pair per tile.
- Results go to ping-pong psum GBFs, which are read back on two output ports.
- Used as the system-level integration block and as a self-test target.

---
 rtl/accelerator_core.sv | 232 +++++++++++++++++++++++
 tb/tb_accelerator_core.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/accelerator_core.sv
// accelerator_core: self-loading ping-pong GBF accelerator with a COL-lane MAC engine.
// Build option ACCEL_SIGNED_EN: signed operands, sign-extended lane accumulation.
module accelerator_core #(
  parameter int ROW                    = 16,
  parameter int COL                    = 16,
  parameter int IN_BITWIDTH            = 8,
  parameter int OUT_BITWIDTH           = 16,
  parameter int ACTV_ADDR_BITWIDTH     = 2,
  parameter int ACTV_DEPTH             = 4,
  parameter int WGT_ADDR_BITWIDTH      = 2,
  parameter int WGT_DEPTH              = 4,
  parameter int PSUM_ADDR_BITWIDTH     = 2,
  parameter int PSUM_DEPTH             = 4,
  parameter int GBF_DATA_BITWIDTH      = 256,
  parameter int GBF_ADDR_BITWIDTH      = 5,
  parameter int GBF_DEPTH              = 32,
  parameter int PSUM_GBF_DATA_BITWIDTH = 512,
  parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
  parameter int PSUM_GBF_DEPTH         = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              actv_gbf1_need_data,
  output logic                              actv_gbf2_need_data,
  output logic                              wgt_gbf1_need_data,
  output logic                              wgt_gbf2_need_data,
  output logic [PSUM_GBF_DATA_BITWIDTH-1:0] r_data1b,
  output logic [PSUM_GBF_DATA_BITWIDTH-1:0] r_data2b,
  output logic                              r_en1b_out,
  output logic                              r_en2b_out
);
  localparam int L = PSUM_GBF_DATA_BITWIDTH / COL;
  localparam logic [GBF_ADDR_BITWIDTH-1:0] GBF_LAST = GBF_ADDR_BITWIDTH'(GBF_DEPTH - 1);

  if (GBF_DATA_BITWIDTH != 2 * COL * IN_BITWIDTH || OUT_BITWIDTH != 2 * IN_BITWIDTH || ROW < 1 ||
      ACTV_DEPTH != (1 << ACTV_ADDR_BITWIDTH) || WGT_DEPTH != (1 << WGT_ADDR_BITWIDTH) ||
      PSUM_DEPTH != (1 << PSUM_ADDR_BITWIDTH) || GBF_DEPTH != (1 << GBF_ADDR_BITWIDTH) ||
      PSUM_GBF_DEPTH != (1 << PSUM_GBF_ADDR_BITWIDTH)) begin : g_bad_cfg
    $error("accelerator_core: inconsistent parameter set");
  end

  // state  | meaning
  // C_IDLE | waiting for both flags of cmp_bank to clear
  // C_RUN  | streaming GBF reads, accumulating the previous word
  // C_LAST | last accumulate, psum word written
  // C_OUT  | psum read back, bank flags re-armed
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_LAST, C_OUT} cmp_state_t;
  cmp_state_t state, state_nx;

  logic [1:0] actv_need, wgt_need;          // index 0 is bank1
  logic       ld_busy, ld_bank, ld_wr_en, ld_wr_bank, ld_last;
  logic [GBF_ADDR_BITWIDTH-1:0] ld_addr, ld_wr_addr, rd_addr;
  logic [IN_BITWIDTH-1:0]       fill_cnt;
  logic [GBF_DATA_BITWIDTH-1:0] ld_actv_word, ld_wgt_word, actv_rd, wgt_rd;
  logic [GBF_DATA_BITWIDTH-1:0] actv_mem [2][GBF_DEPTH];
  logic [GBF_DATA_BITWIDTH-1:0] wgt_mem  [2][GBF_DEPTH];
  logic [PSUM_GBF_DATA_BITWIDTH-1:0] psum_mem [2][PSUM_GBF_DEPTH];
  logic [PSUM_GBF_DATA_BITWIDTH-1:0] psum_word;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] tile_cnt;
  logic [L-1:0] acc [COL];
  logic [L-1:0] acc_nx [COL];
  logic cmp_bank, rd_en, rd_vld, cmp_start, psum_we, cmp_done;

  assign actv_gbf1_need_data = actv_need[0];
  assign actv_gbf2_need_data = actv_need[1];
  assign wgt_gbf1_need_data  = wgt_need[0];
  assign wgt_gbf2_need_data  = wgt_need[1];

  always_comb begin
    ld_wr_en   = 1'b0;
    ld_wr_bank = ld_bank;
    ld_wr_addr = ld_addr;
    if (ld_busy) begin
      ld_wr_en = 1'b1;
    end else if (actv_need[0] && wgt_need[0]) begin
      ld_wr_en   = 1'b1;
      ld_wr_bank = 1'b0;
      ld_wr_addr = '0;
    end else if (actv_need[1] && wgt_need[1]) begin
      ld_wr_en   = 1'b1;
      ld_wr_bank = 1'b1;
      ld_wr_addr = '0;
    end
  end

  assign ld_last = ld_wr_en && (ld_wr_addr == GBF_LAST);

  always_comb begin
    ld_actv_word = '0;
    ld_wgt_word  = '0;
    for (int k = 0; k < 2 * COL; k++) begin
      ld_actv_word[IN_BITWIDTH*k +: IN_BITWIDTH] =
        IN_BITWIDTH'(ld_wr_addr) + IN_BITWIDTH'(k) + fill_cnt;
      ld_wgt_word[IN_BITWIDTH*k +: IN_BITWIDTH] = IN_BITWIDTH'(k % 4 + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_busy  <= 1'b0;
      ld_bank  <= 1'b0;
      ld_addr  <= '0;
      fill_cnt <= '0;
    end else if (ld_wr_en) begin
      ld_bank <= ld_wr_bank;
      if (ld_last) begin
        ld_busy  <= 1'b0;
        ld_addr  <= '0;
        fill_cnt <= fill_cnt + IN_BITWIDTH'(1);
      end else begin
        ld_busy <= 1'b1;
        ld_addr <= ld_wr_addr + GBF_ADDR_BITWIDTH'(1);
      end
    end
  end

  // The loader clears and the engine re-arms; they never touch the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      actv_need <= 2'b11;
      wgt_need  <= 2'b11;
    end else begin
      if (ld_last) begin
        actv_need[ld_wr_bank] <= 1'b0;
        wgt_need[ld_wr_bank]  <= 1'b0;
      end
      if (cmp_done) begin
        actv_need[cmp_bank] <= 1'b1;
        wgt_need[cmp_bank]  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= C_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rd_en     = 1'b0;
    cmp_start = 1'b0;
    psum_we   = 1'b0;
    cmp_done  = 1'b0;
    case (state)
      C_IDLE: if (!actv_need[cmp_bank] && !wgt_need[cmp_bank]) begin
        rd_en     = 1'b1;
        cmp_start = 1'b1;
        state_nx  = C_RUN;
      end
      C_RUN: begin
        rd_en = 1'b1;
        if (rd_addr == GBF_LAST) state_nx = C_LAST;
      end
      C_LAST: begin
        psum_we  = 1'b1;
        state_nx = C_OUT;
      end
      C_OUT: begin
        cmp_done = 1'b1;
        state_nx = C_IDLE;
      end
      default: state_nx = C_IDLE;
    endcase
  end

  for (genvar c = 0; c < COL; c++) begin : g_lane
    logic [IN_BITWIDTH-1:0]  a0, a1, w0, w1;
    logic [OUT_BITWIDTH-1:0] p0, p1;
    assign a0 = actv_rd[IN_BITWIDTH*(2*c)   +: IN_BITWIDTH];
    assign a1 = actv_rd[IN_BITWIDTH*(2*c+1) +: IN_BITWIDTH];
    assign w0 = wgt_rd[IN_BITWIDTH*(2*c)    +: IN_BITWIDTH];
    assign w1 = wgt_rd[IN_BITWIDTH*(2*c+1)  +: IN_BITWIDTH];
`ifdef ACCEL_SIGNED_EN
    assign p0 = OUT_BITWIDTH'($signed(a0)) * OUT_BITWIDTH'($signed(w0));
    assign p1 = OUT_BITWIDTH'($signed(a1)) * OUT_BITWIDTH'($signed(w1));
    assign acc_nx[c] = acc[c] + L'($signed(p0)) + L'($signed(p1));
`else
    assign p0 = OUT_BITWIDTH'(a0) * OUT_BITWIDTH'(w0);
    assign p1 = OUT_BITWIDTH'(a1) * OUT_BITWIDTH'(w1);
    assign acc_nx[c] = acc[c] + L'(p0) + L'(p1);
`endif
    assign psum_word[L*c +: L] = acc_nx[c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr  <= '0;
      rd_vld   <= 1'b0;
      cmp_bank <= 1'b0;
      tile_cnt <= '0;
      for (int c = 0; c < COL; c++) acc[c] <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) rd_addr <= rd_addr + GBF_ADDR_BITWIDTH'(1);
      if (cmp_done) begin
        cmp_bank <= ~cmp_bank;
        tile_cnt <= tile_cnt + PSUM_GBF_ADDR_BITWIDTH'(1);
      end
      for (int c = 0; c < COL; c++) begin
        if (cmp_start)   acc[c] <= '0;
        else if (rd_vld) acc[c] <= acc_nx[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_wr_en) begin
      actv_mem[ld_wr_bank][ld_wr_addr] <= ld_actv_word;
      wgt_mem[ld_wr_bank][ld_wr_addr]  <= ld_wgt_word;
    end
    if (rd_en) begin
      actv_rd <= actv_mem[cmp_bank][rd_addr];
      wgt_rd  <= wgt_mem[cmp_bank][rd_addr];
    end
    if (psum_we) psum_mem[cmp_bank][tile_cnt] <= psum_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data1b   <= '0;
      r_data2b   <= '0;
      r_en1b_out <= 1'b0;
      r_en2b_out <= 1'b0;
    end else begin
      r_en1b_out <= cmp_done && !cmp_bank;
      r_en2b_out <= cmp_done && cmp_bank;
      if (cmp_done && !cmp_bank) r_data1b <= psum_mem[0][tile_cnt];
      if (cmp_done && cmp_bank)  r_data2b <= psum_mem[1][tile_cnt];
    end
  end
endmodule

// File: tb/tb_accelerator_core.sv
// Directed bench for accelerator_core: flag timing, strobe cadence and psum values vs a byte-pattern model.
module tb_accelerator_core;
  localparam int COL = 16;
  localparam int L   = 32;
  localparam int D   = 32;

  logic clk = 1'b0;
  logic reset;
  logic actv_gbf1_need_data, actv_gbf2_need_data, wgt_gbf1_need_data, wgt_gbf2_need_data;
  logic [511:0] r_data1b, r_data2b;
  logic r_en1b_out, r_en2b_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  accelerator_core dut (
    .clk                 (clk),
    .reset               (reset),
    .actv_gbf1_need_data (actv_gbf1_need_data),
    .actv_gbf2_need_data (actv_gbf2_need_data),
    .wgt_gbf1_need_data  (wgt_gbf1_need_data),
    .wgt_gbf2_need_data  (wgt_gbf2_need_data),
    .r_data1b            (r_data1b),
    .r_data2b            (r_data2b),
    .r_en1b_out          (r_en1b_out),
    .r_en2b_out          (r_en2b_out)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] model_lane(input int f, input int c);
    int acc, k, x, w;
    acc = 0;
    for (int a = 0; a < D; a++) begin
      for (int j = 0; j < 2; j++) begin
        k = 2 * c + j;
        x = (a + k + f) % 256;
        w = (k % 4) + 1;
`ifdef ACCEL_SIGNED_EN
        if (x >= 128) x = x - 256;
`endif
        acc = acc + x * w;
      end
    end
    return acc;
  endfunction

  function automatic logic [511:0] model_word(input int f);
    logic [511:0] wd;
    wd = '0;
    for (int c = 0; c < COL; c++) wd[L*c +: L] = model_lane(f, c);
    return wd;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_a1"}, actv_gbf1_need_data, 1);
    check({tag, "_a2"}, actv_gbf2_need_data, 1);
    check({tag, "_w1"}, wgt_gbf1_need_data, 1);
    check({tag, "_w2"}, wgt_gbf2_need_data, 1);
    check({tag, "_en1"}, r_en1b_out, 0);
    check({tag, "_en2"}, r_en2b_out, 0);
    check({tag, "_d1"}, r_data1b, 0);
    check({tag, "_d2"}, r_data2b, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int last);
    bit e1, e2;
    while (cyc <= last) begin
      e1 = (cyc >= 67)  && ((cyc - 67)  % 68 == 0);
      e2 = (cyc >= 101) && ((cyc - 101) % 68 == 0);
      check("r_en1b", r_en1b_out, e1);
      check("r_en2b", r_en2b_out, e2);
      if (e1) check("psum1b", r_data1b, model_word((cyc - 67) / 34));
      if (e2) check("psum2b", r_data2b, model_word((cyc - 67) / 34));
      case (cyc)
        32: begin
          check("a1_before_fill_end", actv_gbf1_need_data, 1);
          check("w1_before_fill_end", wgt_gbf1_need_data, 1);
        end
        33: begin
          check("a1_filled", actv_gbf1_need_data, 0);
          check("w1_filled", wgt_gbf1_need_data, 0);
          check("a2_filling", actv_gbf2_need_data, 1);
        end
        64: begin
          check("a2_before_fill_end", actv_gbf2_need_data, 1);
          check("w2_before_fill_end", wgt_gbf2_need_data, 1);
        end
        65: begin
          check("a2_filled", actv_gbf2_need_data, 0);
          check("w2_filled", wgt_gbf2_need_data, 0);
        end
        66: check("a1_still_in_use", actv_gbf1_need_data, 0);
        67: begin
          check("a1_rearmed", actv_gbf1_need_data, 1);
          check("w1_rearmed", wgt_gbf1_need_data, 1);
          check("t0_lane0", r_data1b[31:0], 1552);
          check("t0_lane1", r_data1b[63:32], 4048);
        end
        90: begin
          check("d1_hold", r_data1b, model_word(0));
          check("d2_untouched", r_data2b, 0);
        end
        98: check("a1_refilling", actv_gbf1_need_data, 1);
        99: begin
          check("a1_refilled", actv_gbf1_need_data, 0);
          check("w1_refilled", wgt_gbf1_need_data, 0);
        end
        100: check("a2_in_use", actv_gbf2_need_data, 0);
        101: begin
          check("a2_rearmed", actv_gbf2_need_data, 1);
          check("w2_rearmed", wgt_gbf2_need_data, 1);
          check("t1_lane0", r_data2b[31:0], 1648);
          check("t1_lane1", r_data2b[63:32], 4272);
        end
        default: ;
      endcase
      step();
    end
  endtask

  initial begin
    cyc   = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");

    reset = 1'b0;
    cyc   = 1;
    run_to(79);

    reset = 1'b1;
    step();
    check_reset_state("midrun_reset");

    reset = 1'b0;
    cyc   = 1;
    run_to(67 + 34 * 210 + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
